// File: rtl/data_mem_burst_master.sv
// Burst initiator for one data-memory lane: turns a core burst request into per-cycle
// Control/Addr/DataIn commands. Define ADDR_CHECK_EN to abort bursts that run past MEM_DEPTH.
module data_mem_burst_master #(
  parameter int LEN_W     = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic             ReqWrite,
  input  logic [15:0]      ReqAddr,
  input  logic [LEN_W-1:0] ReqLen,
  input  logic [15:0]      WrData,
  input  logic             WrValid,
  output logic             WrReady,
  output logic [15:0]      RdData,
  output logic             RdValid,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [1:0]       MemControl,
  output logic [15:0]      MemAddr,
  output logic [15:0]      MemDataIn,
  input  logic [15:0]      MemDataOut
);

`ifdef ADDR_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd2;
  localparam logic [1:0] CMD_WR   = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DRAIN, S_FIN} state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [15:0]      nxt_addr;
  logic             rd_vld_p1;

  function automatic logic addr_bad(input logic [15:0] a);
    return CHECK_EN && (int'(a) >= MEM_DEPTH);
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      rem        <= '0;
      nxt_addr   <= '0;
      rd_vld_p1  <= 1'b0;
      ReqReady   <= 1'b1;
      WrReady    <= 1'b0;
      RdData     <= '0;
      RdValid    <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      MemControl <= CMD_IDLE;
      MemAddr    <= '0;
      MemDataIn  <= '0;
    end else begin
      // read return: memory samples at the edge after a read command, we register one edge later
      rd_vld_p1 <= (MemControl == CMD_RD);
      RdValid   <= rd_vld_p1;
      if (rd_vld_p1) RdData <= MemDataOut;
      Done <= 1'b0;

      case (state)
        S_IDLE: begin
          MemControl <= CMD_IDLE;
          if (ReqValid && ReqReady) begin
            ReqReady <= 1'b0;
            Busy     <= 1'b1;
            Error    <= 1'b0;
            if (ReqLen == '0) begin
              state <= S_DRAIN;
            end else if (addr_bad(ReqAddr)) begin
              Error <= 1'b1;
              state <= S_DRAIN;
            end else if (ReqWrite) begin
              state    <= S_WR;
              WrReady  <= 1'b1;
              nxt_addr <= ReqAddr;
              rem      <= ReqLen;
            end else begin
              state      <= S_RD;
              MemControl <= CMD_RD;
              MemAddr    <= ReqAddr;
              nxt_addr   <= ReqAddr + 16'd1;
              rem        <= ReqLen - LEN_W'(1);
            end
          end
        end

        S_RD: begin
          if (rem == '0) begin
            MemControl <= CMD_IDLE;
            state      <= S_DRAIN;
          end else if (addr_bad(nxt_addr)) begin
            MemControl <= CMD_IDLE;
            Error      <= 1'b1;
            state      <= S_DRAIN;
          end else begin
            MemControl <= CMD_RD;
            MemAddr    <= nxt_addr;
            nxt_addr   <= nxt_addr + 16'd1;
            rem        <= rem - LEN_W'(1);
          end
        end

        S_WR: begin
          if (WrValid) begin
            MemControl <= CMD_WR;
            MemAddr    <= nxt_addr;
            MemDataIn  <= WrData;
            nxt_addr   <= nxt_addr + 16'd1;
            rem        <= rem - LEN_W'(1);
            // close the beat window here so no extra beat is accepted
            if (rem == LEN_W'(1)) begin
              WrReady <= 1'b0;
              state   <= S_DRAIN;
            end else if (addr_bad(nxt_addr + 16'd1)) begin
              WrReady <= 1'b0;
              Error   <= 1'b1;
              state   <= S_DRAIN;
            end
          end else begin
            MemControl <= CMD_IDLE;
          end
        end

        S_DRAIN: begin
          MemControl <= CMD_IDLE;
          // a read still on the bus means its beat has not been registered yet
          if (MemControl != CMD_RD) begin
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= S_FIN;
          end
        end

        S_FIN: begin
          MemControl <= CMD_IDLE;
          ReqReady   <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          MemControl <= CMD_IDLE;
          WrReady    <= 1'b0;
          Busy       <= 1'b0;
          ReqReady   <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_burst_master.sv
// Randomized bench for data_mem_burst_master with a 64K-word memory responder and a
// per-burst reference model that predicts every output cycle by cycle.
module tb_data_mem_burst_master;

  localparam int LEN_W = 8;
`ifdef ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic             Clock = 1'b0;
  logic             Reset;
  logic             ReqValid, ReqWrite, WrValid;
  logic [15:0]      ReqAddr, WrData;
  logic [LEN_W-1:0] ReqLen;
  logic             ReqReady, WrReady, RdValid, Busy, Done, Error;
  logic [15:0]      RdData, MemAddr, MemDataIn;
  logic [15:0]      MemDataOut = 16'd0;
  logic [1:0]       MemControl;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  data_mem_burst_master #(.LEN_W(LEN_W), .MEM_DEPTH(256)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqLen(ReqLen),
    .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady),
    .RdData(RdData), .RdValid(RdValid),
    .Busy(Busy), .Done(Done), .Error(Error),
    .MemControl(MemControl), .MemAddr(MemAddr), .MemDataIn(MemDataIn),
    .MemDataOut(MemDataOut)
  );

  always #5 Clock = ~Clock;

  // memory: read data registered at the read edge, writes committed at the write edge
  always @(posedge Clock) begin
    if (MemControl == 2'd2) MemDataOut <= mem[MemAddr];
    else if (MemControl == 2'd3) mem[MemAddr] = MemDataIn;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [15:0] a);
    return CHECK_EN && (a >= 16'd256);
  endfunction

  // Caller is at a negedge with the master idle. WrValid follows vpat when use_pat, else random.
  task automatic run_burst(input bit wr, input logic [15:0] base, input int len,
                           input logic [15:0] dseed, input logic [31:0] vpat, input bit use_pat);
    int n, hs, done, c, pct;
    bit hs_prev, fin;
    logic [1:0]  exp_ctl;
    logic [15:0] exp_addr, exp_din, ridx;
    bit exp_rv;
    n = 0;
    while (n < len && !addr_bad(base + 16'(n))) n++;
    done = wr ? ((n == 0) ? 1 : -1) : n + 1;
    hs = 0; hs_prev = 1'b0; fin = 1'b0;
    pct = $urandom_range(30, 100);
    check_val("req_ready_idle", 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWrite = wr; ReqAddr = base; ReqLen = LEN_W'(len);
    c = 0;
    while (!fin && c < 400) begin
      @(negedge Clock);
      if (c == 0) begin
        ReqValid = 1'b0; ReqWrite = 1'($urandom);
        ReqAddr = 16'($urandom); ReqLen = LEN_W'($urandom);
      end
      exp_ctl = 2'd0; exp_addr = 16'd0; exp_din = 16'd0;
      if (wr && hs_prev) begin
        exp_ctl = 2'd3; exp_addr = base + 16'(hs - 1); exp_din = dseed + 16'(hs - 1);
      end else if (!wr && c < n) begin
        exp_ctl = 2'd2; exp_addr = base + 16'(c);
      end
      check_val("mem_control", 32'(MemControl), 32'(exp_ctl));
      if (exp_ctl != 2'd0) check_val("mem_addr", 32'(MemAddr), 32'(exp_addr));
      if (exp_ctl == 2'd3) check_val("mem_data_in", 32'(MemDataIn), 32'(exp_din));
      exp_rv = !wr && c >= 2 && (c - 2) < n;
      check_val("rd_valid", 32'(RdValid), 32'(exp_rv));
      if (exp_rv) begin
        ridx = base + 16'(c - 2);
        check_val("rd_data", 32'(RdData), 32'(ref_mem[ridx]));
      end
      check_val("wr_ready", 32'(WrReady), 32'(wr && hs < n));
      check_val("done", 32'(Done), 32'(done >= 0 && c == done));
      check_val("busy", 32'(Busy), 32'(!(done >= 0 && c >= done)));
      check_val("req_ready", 32'(ReqReady), 32'(done >= 0 && c > done));
      if (done >= 0 && c == done) check_val("error", 32'(Error), 32'(n < len));
      if (done >= 0 && c == done + 1) begin
        fin = 1'b1;
      end else begin
        WrValid = use_pat ? (c < 32 && vpat[c]) : ($urandom_range(0, 99) < pct);
        WrData = 16'($urandom);
        hs_prev = 1'b0;
        if (wr && hs < n && WrValid) begin
          WrData = dseed + 16'(hs);
          ref_mem[base + 16'(hs)] = WrData;
          hs++;
          hs_prev = 1'b1;
          if (hs == n) done = c + 2;
        end
        c++;
      end
    end
    WrValid = 1'b0;
    if (!fin) check_val("burst_timeout", 32'(c), 32'(done + 1));
  endtask

  initial begin
    int unsigned v;
    for (int a = 0; a < 65536; a++) begin
      v = 32'(a) * 32'(a) - 32'(5 * a) + 32'd11;
      mem[a] = v[15:0];
      ref_mem[a] = v[15:0];
    end
    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqLen = '0;
    WrValid = 1'b0; WrData = '0;
    repeat (3) @(negedge Clock);
    check_val("rst_req_ready", 32'(ReqReady), 32'd1);
    check_val("rst_busy", 32'(Busy), 32'd0);
    check_val("rst_mem_control", 32'(MemControl), 32'd0);
    check_val("rst_rd_valid", 32'(RdValid), 32'd0);
    check_val("rst_error", 32'(Error), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    run_burst(1'b0, 16'd4, 3, 16'd0, 32'd0, 1'b0);
    run_burst(1'b1, 16'd32, 4, 16'h00A1, 32'b11011, 1'b1);
    run_burst(1'b0, 16'd32, 4, 16'd0, 32'd0, 1'b0);
    run_burst(1'b0, 16'd10, 0, 16'd0, 32'd0, 1'b0);
    run_burst(1'b1, 16'd10, 0, 16'd0, 32'hFFFF_FFFF, 1'b1);
    run_burst(1'b0, 16'hFFFE, 3, 16'd0, 32'd0, 1'b0);
    run_burst(1'b1, 16'hFFFF, 2, 16'h5A00, 32'd0, 1'b0);
    run_burst(1'b0, 16'hFFFF, 2, 16'd0, 32'd0, 1'b0);
`ifdef ADDR_CHECK_EN
    run_burst(1'b0, 16'd254, 4, 16'd0, 32'd0, 1'b0);
    run_burst(1'b1, 16'd253, 5, 16'h7700, 32'd0, 1'b0);
`endif

    // reset in the middle of a read burst, after two beats have come back
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 16'd100; ReqLen = LEN_W'(8);
    @(negedge Clock);
    ReqValid = 1'b0;
    repeat (3) @(negedge Clock);
    check_val("pre_rst_beat", 32'(RdValid), 32'd1);
    Reset = 1'b1;
    #1;
    check_val("mid_rst_mem_control", 32'(MemControl), 32'd0);
    check_val("mid_rst_rd_valid", 32'(RdValid), 32'd0);
    check_val("mid_rst_busy", 32'(Busy), 32'd0);
    check_val("mid_rst_req_ready", 32'(ReqReady), 32'd1);
    check_val("mid_rst_mem_addr", 32'(MemAddr), 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (6) begin
      @(negedge Clock);
      check_val("post_rst_rd_valid", 32'(RdValid), 32'd0);
      check_val("post_rst_done", 32'(Done), 32'd0);
      check_val("post_rst_mem_control", 32'(MemControl), 32'd0);
    end
    run_burst(1'b0, 16'd100, 8, 16'd0, 32'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] b;
      b = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
      if ($urandom_range(0, 2) == 0) b = 16'($urandom_range(240, 255));
      run_burst(1'($urandom), b, $urandom_range(0, 12), 16'($urandom), 32'd0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
